// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: binary write/read pointers, storage strobes/addresses,
// full/empty/count status and registered gray pointer copies. Optional GRAY_FIFO_ERR_FLAG_EN adds sticky error flags.
module gray_fifo_ptr_ctrl #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_i,
   input  logic              pop_i,
`ifdef GRAY_FIFO_ERR_FLAG_EN
   input  logic              clr_err_i,
   output logic              overflow_o,
   output logic              underflow_o,
`endif
   output logic              wr_en_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic [ADDR_W:0]   wr_ptr_gray_o,
   output logic [ADDR_W:0]   rd_ptr_gray_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   count_o
);

   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [ADDR_W:0] wr_nxt;
   logic [ADDR_W:0] rd_nxt;

   function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
      return b ^ (b >> 1);
   endfunction

   // Request/accept handshake: a request (push_i/pop_i) is taken in the cycle it is
   // presented iff the FIFO is not full/empty; the strobe is that accept, and a refused
   // request is simply dropped (the requester must re-present it). Nothing is accepted in reset.
   always_comb begin
      full_o    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
      empty_o   = (wr_ptr == rd_ptr);
      count_o   = wr_ptr - rd_ptr;
      wr_en_o   = push_i & ~full_o & reset_n;
      rd_en_o   = pop_i & ~empty_o & reset_n;
      wr_addr_o = wr_ptr[ADDR_W-1:0];
      rd_addr_o = rd_ptr[ADDR_W-1:0];
      wr_nxt    = wr_ptr + {{ADDR_W{1'b0}}, wr_en_o};
      rd_nxt    = rd_ptr + {{ADDR_W{1'b0}}, rd_en_o};
   end

   // Gray copies are taken from the next binary value so they never lag the pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         wr_ptr_gray_o <= '0;
         rd_ptr_gray_o <= '0;
      end else begin
         wr_ptr        <= wr_nxt;
         rd_ptr        <= rd_nxt;
         wr_ptr_gray_o <= bin2gray(wr_nxt);
         rd_ptr_gray_o <= bin2gray(rd_nxt);
      end
   end

`ifdef GRAY_FIFO_ERR_FLAG_EN
   // Sticky flags: a new refused request wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         overflow_o  <= (push_i & full_o) | (overflow_o & ~clr_err_i);
         underflow_o <= (pop_i & empty_o) | (underflow_o & ~clr_err_i);
      end
   end
`endif

endmodule
